tcm_bus_ctrl: RTL and testbench
===============================

TCM_BUS_CTRL -- requirements
Module: tcm_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, TCM data width in bits; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, TCM byte-address width.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit, reset; synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, 1 bit, request valid.
REQ-006 SHALL have port req_ready_o, output, 1 bit, request accept.
REQ-007 SHALL have port req_addr_i, input, ADDR_WIDTH bits, byte address.
REQ-008 SHALL have ports req_we_i (input, 1 bit) and req_be_i (input, DATA_WIDTH/8 bits), write enable and byte enables.
REQ-009 SHALL have port req_wdata_i, input, DATA_WIDTH bits, write data.
REQ-010 SHALL have ports rsp_valid_o (output, 1 bit) and rsp_ready_i (input, 1 bit), the response handshake.
REQ-011 SHALL have ports rsp_rdata_o (output, DATA_WIDTH bits) and rsp_err_o (output, 1 bit), response read data and error flag.
REQ-012 SHALL have ports tcm_en_o, tcm_we_o (output, 1 bit each), tcm_addr_o (output, ADDR_WIDTH bits), tcm_be_o (output, DATA_WIDTH/8 bits) and tcm_wdata_o (output, DATA_WIDTH bits), the TCM command port.
REQ-013 SHALL have port tcm_rdata_i, input, DATA_WIDTH bits, TCM read data, valid one cycle after a read enable.

Function
REQ-014 SHALL accept a request on a cycle with req_valid_i & req_ready_o.
REQ-015 SHALL, in the accept cycle, combinationally drive tcm_en_o=1, with tcm_we_o, tcm_addr_o, tcm_be_o and tcm_wdata_o taken directly from the req_* inputs; tcm_en_o=0 otherwise.
REQ-016 SHALL produce exactly one response per accepted request (reads and writes), in acceptance order.
REQ-017 SHALL hold a one-entry in-flight stage (inflight, is_read, err) that is set in the accept cycle and clears the following cycle.
REQ-018 SHALL, when inflight=1 and the response FIFO is empty, present the response on the same cycle (bypass): rsp_valid_o=1, rsp_rdata_o=tcm_rdata_i for reads, 0 for writes.
REQ-019 SHALL push the in-flight response into a 2-entry response FIFO when it is not consumed that cycle (FIFO non-empty, or rsp_ready_i=0).
REQ-020 SHALL, when the FIFO is non-empty, present the FIFO head on rsp_*; the head pops on rsp_valid_o & rsp_ready_i.
REQ-021 SHALL keep rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-022 SHALL drive req_ready_o = (fifo_count + inflight) < 2, using registered state only, with no combinational path from rsp_ready_i.
REQ-023 SHALL sustain one request per cycle when rsp_ready_i stays high, giving a read latency of 1 cycle from accept to rsp_valid_o.
REQ-024 SHALL handle a FIFO push and pop in the same cycle with the count unchanged; FIFO pointers wrap modulo 2.
REQ-025 SHALL treat a write with req_be_i=0 as a normal write that is issued to the TCM and responded to.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, clear inflight, the FIFO pointers and fifo_count; all requests are dropped.
REQ-027 SHALL drive these values during and after reset: req_ready_o=1 (after the first reset edge), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, tcm_en_o=0 when req_valid_i=0.
REQ-028 SHALL, when reset is asserted mid-operation, discard pending responses without emitting them; tcm_rdata_i is ignored on the following cycle.

Configuration
REQ-029 SHALL use macro TCM_MISALIGN_CHK_EN; when defined, a request with req_addr_i[1:0]!=0 is accepted, tcm_en_o stays 0, and its response carries rsp_err_o=1 and rsp_rdata_o=0, with ordering and latency the same as REQ-016 and REQ-023.
REQ-030 SHALL, without TCM_MISALIGN_CHK_EN, pass req_addr_i[1:0] through unchanged, and tie rsp_err_o to 0.

Verification
REQ-031 SHALL cover: write 0xDEADBEEF at 0x0100 with be=0xF, then read 0x0100 with rsp_ready_i=1 -> the read rsp_valid_o is one cycle after accept, with rdata 0xDEADBEEF and err 0.
REQ-032 SHALL cover: 4 back-to-back reads with rsp_ready_i=1 -> req_ready_o stays 1 and 4 responses arrive on consecutive cycles, in order.
REQ-033 SHALL cover: rsp_ready_i=0 and 3 reads offered -> 2 accepted then req_ready_o=0, 2 responses held stable; rsp_ready_i=1 -> both drain in order and the third is accepted.
REQ-034 SHALL cover: byte write be=0x2 data 0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
REQ-035 SHALL cover: rst_i pulsed while 2 responses are buffered -> next cycle rsp_valid_o=0, req_ready_o=1, and no stale response appears afterwards.
REQ-036 SHALL cover, with TCM_MISALIGN_CHK_EN: read at 0x0102 -> tcm_en_o=0 and the response has err=1, rdata=0; without the macro, tcm_en_o=1 and err=0.

Source files
------------

// File: rtl/tcm_bus_ctrl.sv
// Purpose: valid/ready front end for a single-port TCM with in-order responses
//          and a 2-entry response buffer.
// Latency: one cycle from request accept to rsp_valid_o. When the buffer is
//          empty the response bypasses it; otherwise it is queued behind it.
// Backpressure: req_ready_o is low while two responses are outstanding. It is
//          computed from registered state only, so it has no path from rsp_ready_i.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o           request handshake
//   req_addr_i/req_we_i/req_be_i/req_wdata_i   request address, write enable,
//                                     byte enables and write data
//   rsp_valid_o/rsp_ready_i           response handshake
//   rsp_rdata_o/rsp_err_o             response read data and error flag
//   tcm_en_o/tcm_we_o/tcm_addr_o/tcm_be_o/tcm_wdata_o   TCM command port
//   tcm_rdata_i                       TCM read data, valid one cycle after a read enable
//
// Optional feature macro: TCM_MISALIGN_CHK_EN. When it is defined, a request
// whose address is not word aligned is accepted but not issued to the TCM. Its
// response has err=1 and rdata=0.

// Small generic synchronous FIFO: registered head, power-of-two DEPTH.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: none internally; the caller must not push when full without popping.
module tcm_bus_ctrl_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop_vld,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_vld) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

module tcm_bus_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // request channel
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic                      req_we_i,
  input  logic [DATA_WIDTH/8-1:0]   req_be_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  // response channel
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  // TCM command port
  output logic                      tcm_en_o,
  output logic                      tcm_we_o,
  output logic [ADDR_WIDTH-1:0]     tcm_addr_o,
  output logic [DATA_WIDTH/8-1:0]   tcm_be_o,
  output logic [DATA_WIDTH-1:0]     tcm_wdata_o,
  input  logic [DATA_WIDTH-1:0]     tcm_rdata_i
);

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  logic       accept;
  logic       misalign;

  // In-flight stage: the request accepted on the previous cycle.
  logic       inflight_q;
  logic       inflight_rd_q;
  logic       inflight_err_q;

  rsp_t       inflight_dat;
  rsp_t       fifo_head;
  rsp_t       rsp_cur;
  logic [1:0] fifo_cnt;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;

`ifdef TCM_MISALIGN_CHK_EN
  assign misalign = (req_addr_i[1:0] != 2'b00);
`else
  // Without the check the low address bits pass straight to the TCM. Because
  // misalign is constant 0, every error bit below is structurally 0.
  assign misalign = 1'b0;
`endif

  // Credit check: at most two responses outstanding (in flight plus buffered).
  assign req_ready_o = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < 3'd2;
  assign accept      = req_valid_i & req_ready_o;

  // The TCM command is issued in the accept cycle, straight from the request.
  assign tcm_en_o    = accept & ~misalign;
  assign tcm_we_o    = req_we_i;
  assign tcm_addr_o  = req_addr_i;
  assign tcm_be_o    = req_be_i;
  assign tcm_wdata_o = req_wdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q     <= 1'b0;
      inflight_rd_q  <= 1'b0;
      inflight_err_q <= 1'b0;
    end else begin
      inflight_q     <= accept;
      inflight_rd_q  <= accept & ~req_we_i;
      inflight_err_q <= accept & misalign;
    end
  end

  // TCM read data is valid only in the cycle after the read enable, so it is
  // captured here: it is used for the bypass or written into the FIFO.
  always_comb begin
    inflight_dat.err   = inflight_err_q;
    inflight_dat.rdata = (inflight_rd_q && !inflight_err_q) ? tcm_rdata_i : '0;
  end

  assign fifo_empty = (fifo_cnt == 2'd0);

  // Ordering: the in-flight response bypasses only when nothing is buffered
  // ahead of it. Otherwise it joins the back of the FIFO.
  assign fifo_push = inflight_q & ~(fifo_empty & rsp_ready_i);
  assign fifo_pop  = ~fifo_empty & rsp_ready_i;

  tcm_bus_ctrl_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (2)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (fifo_push),
    .push_dat (inflight_dat),
    .pop_vld  (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  assign rsp_cur     = fifo_empty ? inflight_dat : fifo_head;
  assign rsp_valid_o = inflight_q | ~fifo_empty;
  // Drive zeros while idle so stale TCM data never leaks onto the bus.
  assign rsp_rdata_o = rsp_valid_o ? rsp_cur.rdata : '0;
  assign rsp_err_o   = rsp_valid_o & rsp_cur.err;

  // The credit check must keep the FIFO from overflowing.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (fifo_push && !fifo_pop) |-> (fifo_cnt < 2'd2));

  // A TCM enable is only ever the direct result of an accepted request.
  a_en_needs_accept : assert property (@(posedge clk_i) disable iff (rst_i)
    tcm_en_o |-> accept);

endmodule

// File: tb/tb_tcm_bus_ctrl.sv
module tb_tcm_bus_ctrl;

  localparam int DW = 32;
  localparam int AW = 15;
  localparam int BW = 4;

`ifdef TCM_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          req_we_i;
  logic [BW-1:0] req_be_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          tcm_en_o;
  logic          tcm_we_o;
  logic [AW-1:0] tcm_addr_o;
  logic [BW-1:0] tcm_be_o;
  logic [DW-1:0] tcm_wdata_o;
  logic [DW-1:0] tcm_rdata_i;

  tcm_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .tcm_en_o    (tcm_en_o),
    .tcm_we_o    (tcm_we_o),
    .tcm_addr_o  (tcm_addr_o),
    .tcm_be_o    (tcm_be_o),
    .tcm_wdata_o (tcm_wdata_o),
    .tcm_rdata_i (tcm_rdata_i)
  );

  // TCM model: 256 words indexed by addr[9:2], one-cycle read latency.
  logic          mem_clr;
  logic [DW-1:0] tcm_mem [256];

  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tcm_mem[i] <= '0;
    end else if (tcm_en_o) begin
      if (tcm_we_o) begin
        for (int b = 0; b < BW; b++)
          if (tcm_be_o[b]) tcm_mem[tcm_addr_o[9:2]][8*b +: 8] <= tcm_wdata_o[8*b +: 8];
      end else begin
        tcm_rdata_i <= tcm_mem[tcm_addr_o[9:2]];
      end
    end
  end

  // Reference model: the memory contents as the requests define them, plus
  // the in-order list of responses still owed to the requester.
  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic [DW-1:0] ref_mem [256];
  exp_t          exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // One clock cycle. Call it at the negedge after setting the inputs. It
  // checks the outputs against the model, advances the model at the posedge,
  // and returns at the following negedge.
  task automatic step();
    bit   rdy_e, mis, acc;
    exp_t e;
    logic [7:0] idx;
    #1;
    mis   = MIS_CHK && (req_addr_i[1:0] != 2'b00);
    rdy_e = (exp_q.size() < 2);
    acc   = req_valid_i && rdy_e;
    chk("req_ready", {31'b0, req_ready_o}, {31'b0, rdy_e});
    chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
      chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_q[0].err});
    end else begin
      chk("idle_rdata", rsp_rdata_o, '0);
      chk("idle_err", {31'b0, rsp_err_o}, '0);
    end
    chk("tcm_en", {31'b0, tcm_en_o}, {31'b0, acc && !mis});
    if (acc && !mis) begin
      chk("tcm_we", {31'b0, tcm_we_o}, {31'b0, req_we_i});
      chk("tcm_addr", {17'b0, tcm_addr_o}, {17'b0, req_addr_i});
      chk("tcm_be", {28'b0, tcm_be_o}, {28'b0, req_be_i});
      chk("tcm_wdata", tcm_wdata_o, req_wdata_i);
    end
    @(posedge clk_i);
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && rsp_ready_i) void'(exp_q.pop_front());
      if (acc) begin
        e.err   = mis;
        e.rdata = '0;
        idx     = req_addr_i[9:2];
        if (!mis) begin
          if (req_we_i) begin
            for (int b = 0; b < BW; b++)
              if (req_be_i[b]) ref_mem[idx][8*b +: 8] = req_wdata_i[8*b +: 8];
          end else begin
            e.rdata = ref_mem[idx];
          end
        end
        exp_q.push_back(e);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_be_i    = be;
    req_wdata_i = d;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs [8];
  logic [AW-1:0] b2b_addr [4];
  logic [DW-1:0] b2b_exp  [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 15'h0100, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 15'h0100, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 15'h0200, 4'hF, 32'h11223344, 32'h0};
    vecs[3] = '{1'b1, 15'h0200, 4'h2, 32'h0000AB00, 32'h0};
    vecs[4] = '{1'b0, 15'h0200, 4'hF, 32'h0,        32'h1122AB44};
    vecs[5] = '{1'b1, 15'h0100, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{1'b0, 15'h0100, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{1'b0, 15'h7FFC, 4'hF, 32'h0,        32'h0};
    b2b_addr = '{15'h0100, 15'h0200, 15'h0100, 15'h0200};
    b2b_exp  = '{32'hDEADBEEF, 32'h1122AB44, 32'hDEADBEEF, 32'h1122AB44};

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    rst_i       = 1'b1;
    mem_clr     = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);

    // Reset state after the first reset edge
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst_tcm_en", {31'b0, tcm_en_o}, 32'd0);
    step();
    rst_i   = 1'b0;
    mem_clr = 1'b0;

    // Table-driven single transactions: the response comes one cycle after accept
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      step();
      set_req(1'b0, 1'b0, '0, '0, '0);
      chk("vec_lat_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("vec_rdata", rsp_rdata_o, vecs[i].exp_rdata);
      chk("vec_err", {31'b0, rsp_err_o}, 32'd0);
      step();
    end

    // Four back-to-back reads at full throughput
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b0, b2b_addr[i], 4'hF, '0);
      chk("b2b_ready", {31'b0, req_ready_o}, 32'd1);
      step();
      chk("b2b_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("b2b_rdata", rsp_rdata_o, b2b_exp[i]);
    end
    set_req(1'b0, 1'b0, '0, '0, '0);
    step();

    // Response backpressure: two accepted, the third waits, responses stay stable
    rsp_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 15'h0100, 4'hF, '0);
    step();
    set_req(1'b1, 1'b0, 15'h0200, 4'hF, '0);
    step();
    set_req(1'b1, 1'b0, 15'h0100, 4'hF, '0);
    chk("bp_ready_low", {31'b0, req_ready_o}, 32'd0);
    chk("bp_head_a", rsp_rdata_o, 32'hDEADBEEF);
    step();
    chk("bp_ready_low2", {31'b0, req_ready_o}, 32'd0);
    chk("bp_stable_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("bp_stable_a", rsp_rdata_o, 32'hDEADBEEF);
    step();
    rsp_ready_i = 1'b1;
    chk("bp_drain_a", rsp_rdata_o, 32'hDEADBEEF);
    step();
    chk("bp_ready_back", {31'b0, req_ready_o}, 32'd1);
    chk("bp_drain_b", rsp_rdata_o, 32'h1122AB44);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    chk("bp_third_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("bp_third_c", rsp_rdata_o, 32'hDEADBEEF);
    step();

    // Misaligned read
    set_req(1'b1, 1'b0, 15'h0102, 4'hF, '0);
    #1;
`ifdef TCM_MISALIGN_CHK_EN
    chk("mis_tcm_en", {31'b0, tcm_en_o}, 32'd0);
`else
    chk("mis_tcm_en", {31'b0, tcm_en_o}, 32'd1);
`endif
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
`ifdef TCM_MISALIGN_CHK_EN
    chk("mis_err", {31'b0, rsp_err_o}, 32'd1);
    chk("mis_rdata", rsp_rdata_o, 32'd0);
`else
    chk("mis_err", {31'b0, rsp_err_o}, 32'd0);
    chk("mis_rdata", rsp_rdata_o, 32'hDEADBEEF);
`endif
    step();

    // Reset while two responses are buffered
    rsp_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 15'h0100, 4'hF, '0);
    step();
    set_req(1'b1, 1'b0, 15'h0200, 4'hF, '0);
    step();
    set_req(1'b0, 1'b0, '0, '0, '0);
    step();
    chk("pre_rst_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("pre_rst_ready", {31'b0, req_ready_o}, 32'd0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("post_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_rsp", {31'b0, rsp_valid_o}, 32'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      logic [9:0] a;
      rst_i       = ($urandom_range(0, 299) == 0);
      a           = {8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      set_req(!rst_i && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              {5'($urandom_range(0, 31)), a}, 4'($urandom), $urandom);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
